// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - ReqCtrl encodings for byte/halfword/word accesses (signed and unsigned)
//  - FSM state enum
//  - helpers: bytes per access and legality of a ReqCtrl code
package lsu_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  // Number of RAM bytes touched by one request; 0 for illegal codes.
  function automatic logic [2:0] ctrl_bytes(input logic [2:0] c);
    case (c)
      CTRL_B, CTRL_BU: ctrl_bytes = 3'd1;
      CTRL_H, CTRL_HU: ctrl_bytes = 3'd2;
      CTRL_W:          ctrl_bytes = 3'd4;
      default:         ctrl_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic ctrl_legal(input logic [2:0] c);
    ctrl_legal = (ctrl_bytes(c) != 3'd0);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled load value.
//  ctrl : latched ReqCtrl
//  val  : assembled bytes, right-aligned (last byte read in [7:0])
//  ext  : extended 32-bit load result
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [31:0] val,
  output logic [31:0] ext
);

  always_comb begin
    ext = val;
    case (ctrl)
      CTRL_B:  ext = {{24{val[7]}}, val[7:0]};
      CTRL_H:  ext = {{16{val[15]}}, val[15:0]};
      CTRL_BU: ext = {24'd0, val[7:0]};
      CTRL_HU: ext = {16'd0, val[15:0]};
      default: ext = val;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store sequencer between the memory stage and a byte-wide
// synchronous RAM. Big-endian: the lowest address holds the MSB.
//  clk, rst_n             : clock, synchronous active-low reset
//  ReqValid/ReqReady      : request handshake (ReqReady only in IDLE)
//  ReqAddr/ReqWr/ReqCtrl/ReqWrData : request fields, latched on acceptance
//  RspValid/RspReady      : response handshake, response held until taken
//  RspData/RspErr         : extended load data / error flag
//  MemAddr/MemWr/MemWrData/MemRdData : byte RAM port (1-cycle read latency)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [31:0]       ReqAddr,
  input  logic              ReqWr,
  input  logic [2:0]        ReqCtrl,
  input  logic [31:0]       ReqWrData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [31:0]       RspData,
  output logic              RspErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWr,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] base;
  logic [2:0]        ctrl;
  logic              wr;
  logic [31:0]       wdata;
  logic [1:0]        cnt;
  logic [31:0]       shreg;
  logic              err;

  // Request legality, checked on the live inputs in IDLE. The end address is
  // computed at 33 bits so a wrap past 0xFFFFFFFF is caught as out of range.
  logic [2:0]  req_n;
  logic [32:0] req_end;
  logic        req_bad;

  assign req_n   = ctrl_bytes(ReqCtrl);
  assign req_end = {1'b0, ReqAddr} + {30'd0, req_n} - 33'd1;
  assign req_bad = !ctrl_legal(ReqCtrl) || (ReqWr && ReqCtrl[2]) ||
                   (req_end > 33'(DEPTH - 1));

  logic [2:0] n_m1;
  logic       last;
  assign n_m1 = ctrl_bytes(ctrl) - 3'd1;
  assign last = (cnt == n_m1[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ReqValid) state_nx = req_bad ? RESP : ACCESS;
      ACCESS:  if (last)     state_nx = wr ? RESP : DRAIN;
      DRAIN:                 state_nx = RESP;
      RESP:    if (RspReady) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so the byte for index k arrives
  // during index k+1 (or DRAIN for the last byte).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base  <= '0;
      ctrl  <= '0;
      wr    <= 1'b0;
      wdata <= '0;
      cnt   <= '0;
      shreg <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ReqValid) begin
          base  <= ReqAddr[ADDR_W-1:0];
          ctrl  <= ReqCtrl;
          wr    <= ReqWr;
          wdata <= ReqWrData;
          cnt   <= '0;
          shreg <= '0;
          err   <= req_bad;
        end
        ACCESS: begin
          cnt <= cnt + 2'd1;
          if (!wr && cnt != 2'd0) shreg <= {shreg[23:0], MemRdData};
        end
        DRAIN: shreg <= {shreg[23:0], MemRdData};
        default: ;
      endcase
    end
  end

  logic [31:0] ext;
  lsu_extend u_ext (.ctrl(ctrl), .val(shreg), .ext(ext));

  // Store byte k is the k-th most significant of the N used bytes.
  logic [1:0]  wsel;
  logic [31:0] wsh;
  assign wsel = n_m1[1:0] - cnt;
  assign wsh  = wdata >> {wsel, 3'b000};

  // Outputs are gated by rst_n so they sit at reset values for the whole
  // reset window; in particular a store in flight stops writing immediately.
  logic in_access, in_resp;
  assign in_access = rst_n && (state == ACCESS);
  assign in_resp   = rst_n && (state == RESP);

  assign ReqReady  = !rst_n || (state == IDLE);
  assign MemAddr   = in_access ? base + ADDR_W'(cnt) : '0;
  assign MemWr     = in_access && wr;
  assign MemWrData = (in_access && wr) ? wsh[7:0] : 8'd0;
  assign RspValid  = in_resp;
  assign RspErr    = in_resp && err;
  assign RspData   = (in_resp && !err && !wr) ? ext : 32'd0;

endmodule
